alu_hilo_exec: RTL

- Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the operation.
- Logical, add/sub and SLT ops: registered result, 1 cycle.
- MULT/DIV: iterative, signed, multi-cycle; results go to internal HI/LO registers, read back with MFHI/MFLO.
- Drives a ready/busy handshake so the pipeline stalls during multiply/divide.

---
 rtl/alu_ctrl_pkg.sv | 35 +++
 rtl/md_iter_core.sv | 85 ++++++++
 rtl/alu_hilo_exec.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the execution-stage ALU: control codes (same values
// the ALU control decoder emits), mult/div FSM encoding and default width.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF = 32;

  // ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_DIV  = 4'b1000;
  localparam logic [3:0] ALU_MFHI = 4'b0011;
  localparam logic [3:0] ALU_MFLO = 4'b0100;

  // Mult/div sequencer states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL_ITER = 2'd1;
  localparam logic [1:0] ST_DIV_ITER = 2'd2;
  localparam logic [1:0] ST_FIXUP    = 2'd3;

  // Sequencer control word; the state field is the FSM state, the rest is
  // what the sign fix-up needs once the unsigned core has finished.
  typedef struct packed {
    logic [1:0] state;
    logic       is_div;    // operation in flight is DIV (else MULT)
    logic       div_zero;  // divisor was zero at acceptance
    logic       neg_q;     // product / quotient must be negated
    logic       neg_r;     // remainder must be negated (dividend sign)
  } md_ctl_t;

endpackage

// File: rtl/md_iter_core.sv
// Unsigned iterative multiply / restoring divide core, one bit per cycle,
// DATA_W cycles per operation. Operates on magnitudes only; the owner applies
// signs. done is high during the cycle whose closing edge performs the final
// iteration, so the raw results are stable from the following cycle onward.
module md_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_div,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     mag_a,
  input  logic [DATA_W-1:0]     mag_b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product,
  output logic [DATA_W-1:0]     quot,
  output logic [DATA_W-1:0]     rem
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              busy;
  logic              div_mode;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] upper;    // product high half / partial remainder
  logic [DATA_W-1:0] lower;    // multiplier shifting out / quotient shifting in
  logic [DATA_W-1:0] operand;  // multiplicand / divisor
  logic [DATA_W-1:0] upper_nxt;
  logic [DATA_W-1:0] lower_nxt;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W-1:0] div_diff;
  logic              div_fits;

  assign done    = busy && (cnt == CNT_W'(DATA_W - 1));
  assign product = {upper, lower};
  assign quot    = lower;
  assign rem     = upper;

  // One shift-add or shift-subtract step of the datapath
  always_comb begin
    mul_sum   = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
    div_shift = {upper, lower[DATA_W-1]};
    div_fits  = (div_shift >= {1'b0, operand});
    // Only used when it fits, so the true difference is below 2^DATA_W.
    div_diff  = div_shift[DATA_W-1:0] - operand;
    if (div_mode) begin
      upper_nxt = div_fits ? div_diff : div_shift[DATA_W-1:0];
      lower_nxt = {lower[DATA_W-2:0], div_fits};
    end else begin
      upper_nxt = mul_sum[DATA_W:1];
      lower_nxt = {mul_sum[0], lower[DATA_W-1:1]};
    end
  end

  // Load operands on start, iterate while busy, stop on abort or last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
      upper    <= '0;
      lower    <= '0;
      operand  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      cnt      <= '0;
      upper    <= '0;
      lower    <= mag_a;
      operand  <= mag_b;
    end else if (busy) begin
      if (abort) begin
        busy <= 1'b0;
      end else begin
        upper <= upper_nxt;
        lower <= lower_nxt;
        cnt   <= cnt + CNT_W'(1);
        if (done) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_hilo_exec.sv
// Execution-stage ALU with HI/LO registers. Logical, add/sub, SLT and
// MFHI/MFLO complete in one cycle; signed MULT/DIV run on md_iter_core and
// write HI/LO after a sign fix-up cycle.
// Handshake: an op is accepted on a rising edge where op_valid && op_ready;
// op_ready is high only while the sequencer is idle, and a requester seeing
// op_ready low must hold op_valid and its operands until accepted.
// Build option: ALU_FAST_MUL_EN selects a single-cycle combinational MULT
// (IDLE -> FIXUP directly); DIV is iterative in both builds.
module alu_hilo_exec
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              abort,
  output logic              res_valid,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              md_done,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  md_ctl_t             ctl;
  logic [DATA_W-1:0]   dividend;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   hi_nxt;
  logic [DATA_W-1:0]   lo_nxt;
  logic [DATA_W-1:0]   quot_s;
  logic [DATA_W-1:0]   rem_s;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic                accept;
  logic                core_start;
  logic                core_done;
  logic [2*DATA_W-1:0] core_prod;
  logic [DATA_W-1:0]   core_quot;
  logic [DATA_W-1:0]   core_rem;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (-x) : x;
  endfunction

  assign op_ready = (ctl.state == ST_IDLE);
  assign accept   = op_valid && op_ready;
  assign mag_a    = magnitude(src_a);
  assign mag_b    = magnitude(src_b);

`ifdef ALU_FAST_MUL_EN
  logic [2*DATA_W-1:0]        fast_prod;
  logic signed [2*DATA_W-1:0] fast_mul;
  assign fast_mul   = $signed({{DATA_W{src_a[DATA_W-1]}}, src_a}) *
                      $signed({{DATA_W{src_b[DATA_W-1]}}, src_b});
  assign core_start = accept && (alu_ctrl == ALU_DIV);
`else
  assign core_start = accept && ((alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_DIV));
`endif

  md_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .is_div  (alu_ctrl == ALU_DIV),
    .abort   (abort),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .done    (core_done),
    .product (core_prod),
    .quot    (core_quot),
    .rem     (core_rem)
  );

  // Single-cycle result; undefined codes (and MULT/DIV) yield zero
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_NOR:  alu_res = ~(src_a | src_b);
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  // Sign fix-up of the raw core results into HI/LO values
  always_comb begin
    quot_s = ctl.neg_q ? (-core_quot) : core_quot;
    rem_s  = ctl.neg_r ? (-core_rem) : core_rem;
    hi_nxt = rem_s;
    lo_nxt = quot_s;
    if (ctl.is_div) begin
      if (ctl.div_zero) begin
        hi_nxt = dividend;
        lo_nxt = '1;
      end
    end else begin
`ifdef ALU_FAST_MUL_EN
      {hi_nxt, lo_nxt} = fast_prod;
`else
      {hi_nxt, lo_nxt} = ctl.neg_q ? (-core_prod) : core_prod;
`endif
    end
  end

  // Handshake, sequencer FSM, single-cycle result and HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl       <= '0;
      dividend  <= '0;
      result    <= '0;
      zero      <= 1'b1;
      res_valid <= 1'b0;
      md_done   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef ALU_FAST_MUL_EN
      fast_prod <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      md_done   <= 1'b0;
      case (ctl.state)
        ST_IDLE: begin
          if (op_valid) begin
            if (alu_ctrl == ALU_MULT) begin
              ctl.is_div <= 1'b0;
              ctl.neg_q  <= src_a[DATA_W-1] ^ src_b[DATA_W-1];
`ifdef ALU_FAST_MUL_EN
              fast_prod  <= $unsigned(fast_mul);
              ctl.state  <= ST_FIXUP;
`else
              ctl.state  <= ST_MUL_ITER;
`endif
            end else if (alu_ctrl == ALU_DIV) begin
              ctl.is_div   <= 1'b1;
              ctl.div_zero <= (src_b == '0);
              ctl.neg_q    <= src_a[DATA_W-1] ^ src_b[DATA_W-1];
              ctl.neg_r    <= src_a[DATA_W-1];
              dividend     <= src_a;
              ctl.state    <= ST_DIV_ITER;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              res_valid <= 1'b1;
            end
          end
        end
        ST_MUL_ITER, ST_DIV_ITER: begin
          if (abort)          ctl.state <= ST_IDLE;
          else if (core_done) ctl.state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          // abort is deliberately ignored here: the write always completes
          hi_q      <= hi_nxt;
          lo_q      <= lo_nxt;
          md_done   <= 1'b1;
          ctl.state <= ST_IDLE;
        end
        default: ctl.state <= ST_IDLE;
      endcase
    end
  end

endmodule
